// File: rtl/audio_mix_dac.sv
`default_nettype none
// ============================================================================
//  Module      : audio_mix_dac
//  Description : Multi-channel audio mixer (channel mean) feeding a 1-bit
//                modulator, selectable between first-order delta-sigma and
//                counter-compare PWM. New levels and modes only take effect
//                at a modulator period boundary.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_mix_dac #(
   parameter int WIDTH    = 6,
   parameter int CHANNELS = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        sample_valid,
   output logic                        sample_ready,
   input  logic [CHANNELS*WIDTH-1:0]   sample_data,
   input  logic [CHANNELS-1:0]         ch_enable,
   input  logic                        mode,
   output logic                        pwm
);

   localparam int LOG2C = $clog2(CHANNELS);
   localparam int c_SW  = WIDTH + LOG2C;
   localparam int c_IW  = (LOG2C > 0) ? LOG2C : 1;

   localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(CHANNELS - 1);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_ACCUM  = 2'd1;
   localparam logic [1:0] c_COMMIT = 2'd2;

   // Mixer state
   logic [1:0]                r_state;
   logic                      r_ready;
   logic [CHANNELS*WIDTH-1:0] r_held_data;
   logic [CHANNELS-1:0]       r_held_en;
   logic [c_IW-1:0]           r_idx;
   logic [c_SW-1:0]           r_sum;
   logic [WIDTH-1:0]          r_level_pend;

   // Modulator state
   logic [WIDTH-1:0]          r_cnt;
   logic [WIDTH-1:0]          r_level_act;
   logic                      r_active_mode;
   logic [WIDTH-1:0]          r_accum;
   logic                      r_pwm;

   logic [WIDTH-1:0]          w_sample;
   logic [WIDTH:0]            w_ds_next;
   logic                      w_xfer;
   logic                      w_cnt_max;

   assign w_xfer       = sample_valid & r_ready;
   assign w_cnt_max    = (r_cnt == {WIDTH{1'b1}});
   assign sample_ready = r_ready;
   assign pwm          = r_pwm;

   // Contribution of the channel currently being accumulated (zero when gated off)
   always_comb begin
      w_sample = '0;
      if (r_held_en[r_idx])
         w_sample = r_held_data[r_idx*WIDTH +: WIDTH];
   end

   // Delta-sigma step; the carry out is the modulator output bit
   assign w_ds_next = {1'b0, r_accum} + {1'b0, r_level_act};

   // Low sum bits are discarded by the mean; they only feed this sink
   generate
      if (LOG2C > 0) begin : g_sum_lsb
         logic w_unused_lsb;
         assign w_unused_lsb = ^r_sum[c_IW-1:0];
      end
   endgenerate

   // Mixer FSM: capture a sample set, sum the enabled channels, commit the mean
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= c_IDLE;
         r_ready      <= 1'b1;
         r_held_data  <= '0;
         r_held_en    <= '0;
         r_idx        <= '0;
         r_sum        <= '0;
         r_level_pend <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_xfer) begin
                  r_held_data <= sample_data;
                  r_held_en   <= ch_enable;
                  r_idx       <= '0;
                  r_sum       <= '0;
                  r_ready     <= 1'b0;
                  r_state     <= c_ACCUM;
               end
            end
            c_ACCUM: begin
               r_sum <= r_sum + c_SW'(w_sample);
               r_idx <= r_idx + 1'b1;
               if (r_idx == c_LAST_IDX)
                  r_state <= c_COMMIT;
            end
            c_COMMIT: begin
               r_level_pend <= r_sum[c_SW-1:LOG2C];
               r_ready      <= 1'b1;
               r_state      <= c_IDLE;
            end
            default: begin
               r_state <= c_IDLE;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   // Modulator: free-running period counter, boundary-synchronous level/mode
   // load, and the 1-bit output in the currently active mode
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt         <= '0;
         r_level_act   <= '0;
         r_active_mode <= 1'b0;
         r_accum       <= '0;
         r_pwm         <= 1'b0;
      end else begin
         r_cnt <= r_cnt + 1'b1;

         if (w_cnt_max) begin
            r_level_act   <= r_level_pend;
            r_active_mode <= mode;
         end

         if (r_active_mode)
            r_pwm <= (r_cnt < r_level_act);
         else
            r_pwm <= w_ds_next[WIDTH];

         // The accumulator restarts whenever the active mode flips, so the
         // delta-sigma phase is deterministic after a mode change
         if (w_cnt_max && (mode != r_active_mode))
            r_accum <= '0;
         else if (!r_active_mode)
            r_accum <= w_ds_next[WIDTH-1:0];
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_audio_mix_dac.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_mix_dac
//  Description : Directed self-checking bench for audio_mix_dac
//                (WIDTH=6, CHANNELS=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_mix_dac;

   localparam int WIDTH    = 6;
   localparam int CHANNELS = 4;

   logic                      clk;
   logic                      rst;
   logic                      sample_valid;
   logic                      sample_ready;
   logic [CHANNELS*WIDTH-1:0] sample_data;
   logic [CHANNELS-1:0]       ch_enable;
   logic                      mode;
   logic                      pwm;

   int n_assert;
   int n_fail;

   // Bench copy of the period counter (same reset/increment rule as the DUT's)
   logic [WIDTH-1:0] tb_cnt;

   audio_mix_dac #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .sample_data  (sample_data),
      .ch_enable    (ch_enable),
      .mode         (mode),
      .pwm          (pwm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Track the period counter position
   always @(posedge clk) begin
      if (rst) tb_cnt <= '0;
      else     tb_cnt <= tb_cnt + 1'b1;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_cnt(input int v);
      int n;
      n = 0;
      while (int'(tb_cnt) != v && n < 200) begin
         tick();
         n++;
      end
      chk("wait_cnt", 32'(tb_cnt), 32'(v));
   endtask

   // Offer one sample set, then let the mixer run to completion
   task automatic do_xfer(input logic [CHANNELS*WIDTH-1:0] d, input logic [CHANNELS-1:0] en);
      sample_valid = 1'b1;
      sample_data  = d;
      ch_enable    = en;
      tick();
      sample_valid = 1'b0;
      repeat (5) tick();
   endtask

   initial begin : stim
      int ones;
      int bad;
      logic prev;

      n_assert     = 0;
      n_fail       = 0;
      rst          = 1'b1;
      sample_valid = 1'b0;
      sample_data  = '0;
      ch_enable    = '0;
      mode         = 1'b0;
      repeat (3) tick();

      // Reset state
      chk("rst_ready", 32'(sample_ready), 32'd1);
      chk("rst_pwm", 32'(pwm), 32'd0);
      chk("rst_level_pend", 32'(dut.r_level_pend), 32'd0);
      rst = 1'b0;

      // Handshake: all channels 32, busy-window pulses must not be captured
      sample_valid = 1'b1;
      sample_data  = {6'd32, 6'd32, 6'd32, 6'd32};
      ch_enable    = 4'b1111;
      tick();
      sample_data  = '0;
      ch_enable    = 4'b0000;
      chk("hs_busy_T1", 32'(sample_ready), 32'd0);
      for (int k = 2; k <= 5; k++) begin
         tick();
         chk($sformatf("hs_busy_T%0d", k), 32'(sample_ready), 32'd0);
      end
      chk("hs_pend_before_commit", 32'(dut.r_level_pend), 32'd0);
      tick();
      sample_valid = 1'b0;
      chk("hs_ready_back", 32'(sample_ready), 32'd1);
      chk("hs_level_32", 32'(dut.r_level_pend), 32'd32);

      // Delta-sigma at level 32: strictly alternating, 32 ones per period
      wait_cnt(63);
      tick();
      tick();
      ones = 0;
      bad  = 0;
      prev = pwm;
      for (int k = 0; k < 64; k++) begin
         if (k > 0 && pwm === prev) bad++;
         if (pwm === 1'b1) ones++;
         prev = pwm;
         tick();
      end
      chk("ds32_ones", 32'(ones), 32'd32);
      chk("ds32_alternation_breaks", 32'(bad), 32'd0);

      // Partial enables and all-disabled
      do_xfer({6'd0, 6'd63, 6'd0, 6'd63}, 4'b0101);
      chk("mix_0101", 32'(dut.r_level_pend), 32'd31);
      do_xfer({6'd63, 6'd63, 6'd63, 6'd63}, 4'b0000);
      chk("mix_0000", 32'(dut.r_level_pend), 32'd0);
      wait_cnt(63);
      tick();
      tick();
      ones = 0;
      for (int k = 0; k < 64; k++) begin
         if (pwm !== 1'b0) ones++;
         tick();
      end
      chk("ds0_ones", 32'(ones), 32'd0);

      // PWM mode at level 16: high for counter 0..15 of each period
      mode = 1'b1;
      do_xfer({6'd16, 6'd16, 6'd16, 6'd16}, 4'b1111);
      chk("mix_16", 32'(dut.r_level_pend), 32'd16);
      wait_cnt(63);
      tick();
      for (int p = 0; p < 2; p++) begin
         bad = 0;
         for (int k = 0; k < 64; k++) begin
            tick();
            if (pwm !== ((6'(tb_cnt - 6'd1)) < 6'd16)) bad++;
         end
         chk($sformatf("pwm16_period%0d_errors", p), 32'(bad), 32'd0);
      end

      // Mode switch at counter 20: PWM waveform persists until the wrap,
      // then delta-sigma from a cleared accumulator (ones at cnt%4==0)
      wait_cnt(20);
      mode = 1'b0;
      bad  = 0;
      do begin
         tick();
         if (pwm !== ((6'(tb_cnt - 6'd1)) < 6'd16)) bad++;
      end while (tb_cnt != 6'd0);
      chk("switch_pre_wrap_errors", 32'(bad), 32'd0);
      bad = 0;
      for (int k = 1; k < 64; k++) begin
         tick();
         if (pwm !== (tb_cnt[1:0] == 2'b00)) bad++;
      end
      chk("switch_ds16_errors", 32'(bad), 32'd0);

      // Reset in the middle of accumulation
      sample_valid = 1'b1;
      sample_data  = {6'd40, 6'd40, 6'd40, 6'd40};
      ch_enable    = 4'b1111;
      tick();
      sample_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_ready", 32'(sample_ready), 32'd1);
      chk("midrst_pwm", 32'(pwm), 32'd0);
      chk("midrst_level_pend", 32'(dut.r_level_pend), 32'd0);
      do_xfer({6'd32, 6'd24, 6'd16, 6'd8}, 4'b1111);
      chk("midrst_next_mix", 32'(dut.r_level_pend), 32'd20);

      // Full-scale PWM: 63 ones per 64-cycle period
      mode = 1'b1;
      do_xfer({6'd63, 6'd63, 6'd63, 6'd63}, 4'b1111);
      chk("mix_63", 32'(dut.r_level_pend), 32'd63);
      wait_cnt(63);
      tick();
      ones = 0;
      for (int k = 0; k < 64; k++) begin
         tick();
         if (pwm === 1'b1) ones++;
      end
      chk("pwm63_ones", 32'(ones), 32'd63);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   // Absolute time bound
   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
